// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I ALU instruction encoder.
// Holds the ALU opcodes, the funct3 codes that matter to the packer,
// the FSM state encoding and a small shift-detect helper.
package instr_encoder_pkg;

  localparam logic [6:0] OP_ALU   = 7'h33;  // R-type register-register ALU
  localparam logic [6:0] OP_ALU_I = 7'h13;  // I-type register-immediate ALU

  localparam logic [2:0] F3_ADD = 3'b000;   // ADD/SUB
  localparam logic [2:0] F3_SLL = 3'b001;   // shift left logical
  localparam logic [2:0] F3_SR  = 3'b101;   // SRL/SRA

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Immediate shifts carry a 5-bit shamt plus funct7 instead of a 12-bit immediate.
  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field-to-word packer.
// Ports: alu_src selects R-type (1) or I-type (0); rs1/rs2/rd register indices;
// alu_op = {funct7[5], funct3}; imm = I-type immediate (shamt in [4:0] for shifts);
// word = packed 32-bit instruction; illegal = tuple has no valid RV32I encoding.
module instr_encoder_pack
  import instr_encoder_pkg::*;
(
  input  logic        alu_src,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [3:0]  alu_op,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [2:0] f3_s;
  assign f3_s = alu_op[2:0];

  // Pack the fields and flag funct7[5] on an opcode that has no alternate form.
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    if (alu_src) begin
      // Only ADD/SUB and SRL/SRA have a funct7[5]=1 variant.
      word    = {1'b0, alu_op[3], 5'b00000, rs2, rs1, f3_s, rd, OP_ALU};
      illegal = alu_op[3] && (f3_s != F3_ADD) && (f3_s != F3_SR);
    end else if (is_shift(f3_s)) begin
      // SLLI/SRLI/SRAI: upper immediate bits become funct7.
      word    = {1'b0, alu_op[3], 5'b00000, imm[4:0], rs1, f3_s, rd, OP_ALU_I};
      illegal = alu_op[3] && (f3_s != F3_SR);
    end else begin
      // No SUBI exists, so funct7[5] is never legal here.
      word    = {imm, rs1, f3_s, rd, OP_ALU_I};
      illegal = alu_op[3];
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes ALU field tuples and writes them sequentially into
// the instruction memory write port, one word per two cycles.
// Ports: clk/rst_n clock and async active-low reset; start (re)starts a load at
// BASE_ADDR; in_valid/in_ready tuple handshake; alu_src/rs1/rs2/rd/alu_op/imm/last
// tuple fields; mem_we/mem_addr/mem_wdata memory write port; count words written;
// done load finished; full DEPTH words written; err sticky illegal-tuple flag.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              alu_src,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [3:0]        alu_op,
  input  logic [11:0]       imm,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);

  state_t             state_r;
  state_t             state_s;
  logic [31:0]        word_r;
  logic               last_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [ADDR_W:0]    count_r;
  logic               done_r;
  logic               full_r;
  logic               err_r;
  logic [31:0]        pack_word_s;
  logic               pack_illegal_s;
  logic               at_end_s;

  instr_encoder_pack u_pack (
    .alu_src (alu_src),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .alu_op  (alu_op),
    .imm     (imm),
    .word    (pack_word_s),
    .illegal (pack_illegal_s)
  );

  assign at_end_s = (addr_r == LAST_ADDR);

  // START overrides the state, so it also suppresses handshake and pending write.
  assign in_ready  = (state_r == S_LOAD) && !start;
  assign mem_we    = (state_r == S_WRITE) && !start;
  assign mem_addr  = addr_r;
  assign mem_wdata = word_r;
  assign count     = count_r;
  assign done      = done_r;
  assign full      = full_r;
  assign err       = err_r;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    if (start) begin
      state_s = S_LOAD;
    end else begin
      case (state_r)
        S_IDLE:  state_s = S_IDLE;
        S_LOAD:  state_s = (in_valid && !pack_illegal_s) ? S_WRITE : S_LOAD;
        S_WRITE: state_s = (last_r || at_end_s) ? S_DONE : S_LOAD;
        S_DONE:  state_s = S_DONE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State, captured word, address/count and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      word_r  <= 32'h0000_0000;
      last_r  <= 1'b0;
      addr_r  <= FIRST_ADDR;
      count_r <= '0;
      done_r  <= 1'b0;
      full_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start) begin
        addr_r  <= FIRST_ADDR;
        count_r <= '0;
        done_r  <= 1'b0;
        full_r  <= 1'b0;
        err_r   <= 1'b0;
      end else begin
        case (state_r)
          S_LOAD: begin
            if (in_valid) begin
              if (pack_illegal_s) begin
                err_r <= 1'b1;
              end else begin
                word_r <= pack_word_s;
                last_r <= last;
              end
            end
          end
          S_WRITE: begin
            count_r <= count_r + CNT_ONE;
            // Address holds at the last word so it never wraps.
            if (at_end_s) begin
              full_r <= 1'b1;
              done_r <= 1'b1;
            end else begin
              addr_r <= addr_r + ADDR_ONE;
              if (last_r) begin
                done_r <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
